wb_ldm_sequencer: RTL and testbench
===================================

Name: wb_ldm_sequencer

Overview:
Register-file writeback unit for the Cortex-M0 core. It generalises the writeback data mux into a clocked block that owns both paths into the register file. The single-write path selects ALU, memory or link data and registers it. The multi-register sequencer walks an LDM/POP register list, issues one memory read per set bit, and writes each returned word to the matching register. It sits between the execute/memory stages and the register file write port and stalls the pipeline while a list is in flight.

Parameters:
DW, 32, datapath width in bits.
NREG, 16, register count and register-list width (8 for Thumb low-register LDM, 16 for full POP incl. PC).
AW, 4, register index width; must equal clog2(NREG).

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  synchronous reset, active-high
wb_src  input  3  single-write source: 0 ALU, 1 MEM, 5 BLX link, 6 BL link
wb_en  input  1  single-write request this cycle
wb_addr  input  AW  single-write destination register
alu_result  input  DW  ALU result
r_mem_data_with_extend  input  DW  extended load data for single loads
pc_real  input  DW  current PC for link generation
ldm_start  input  1  start multi-register load (one-cycle pulse)
ldm_list  input  NREG  register list, bit i = register i
ldm_base  input  DW  first word address
mem_req  output  1  multi-load read request
mem_addr  output  DW  multi-load read address
mem_rvalid  input  1  read data valid, completes the current request
mem_rdata  input  DW  read data
w_reg_en  output  1  register-file write enable
w_reg_addr  output  AW  register-file write index
w_reg_data  output  DW  register-file write data
ldm_busy  output  1  sequencer active; pipeline must stall
ldm_done  output  1  one-cycle pulse at end of sequence
pc_load  output  1  qualifies a write to register NREG-1 from the sequencer

Behaviour:
- Reset: all outputs 0, FSM in IDLE, latched list and address cleared. Reset mid-sequence aborts it with no further writes and no ldm_done.
- FSM states:
  - IDLE: no multi-load in progress.
  - REQ: mem_req=1, mem_addr = current address, held stable until mem_rvalid.
  - LAST: one cycle; ldm_done=1, then return to IDLE.
- Single-write path (IDLE only): if wb_en, the next cycle drives w_reg_en=1 and w_reg_addr=wb_addr, with w_reg_data selected by wb_src:
  - 0: alu_result
  - 1: r_mem_data_with_extend
  - 5: {pc_real[DW-1:1],1'b1}
  - 6: {pc_real[DW-1:1],1'b1} - 2, truncated modulo 2^DW
  - any other code: w_reg_en=0 and w_reg_data holds its previous value.
  Latency is 1 cycle.
- Start, IDLE with ldm_start=1:
  - Non-zero list: latch ldm_list and ldm_base, go to REQ, ldm_busy=1 from the next cycle.
  - Zero list: go straight to LAST; no mem_req, no writes.
  - If ldm_start and wb_en arrive together, ldm_start wins and the single write is dropped.
- Ordering: registers are loaded lowest set bit first; the address advances by DW/8 per word and wraps modulo 2^DW.
- On mem_rvalid in REQ:
  - Next cycle: w_reg_en=1, w_reg_addr = lowest set bit index, w_reg_data = mem_rdata. pc_load=1 if the index is NREG-1.
  - Clear that bit and advance the address.
  - If no bits remain, go to LAST; otherwise stay in REQ with the new address on the following cycle.
- mem_rvalid outside REQ is ignored.
- Busy rules:
  - ldm_busy=1 in REQ and LAST.
  - ldm_start and wb_en are ignored while busy; the upstream stage holds its instruction.
- Throughput: one register per cycle when mem_rvalid returns in the same cycle as the request.
- w_reg_en is never high for two different sources in the same cycle.

Test Plan:
1. Single writes. wb_en=1, wb_addr=3, wb_src=0, alu_result=0x1234 -> next cycle w_reg_en=1, addr 3, data 0x1234. wb_src=6, pc_real=0x100 -> data 0xFF. wb_src=5 -> data 0x101. wb_src=2 -> w_reg_en=0.
2. Basic multi-load. ldm_list=0x0091, ldm_base=0x2000, mem_rvalid tied high:
   - Writes R0, R4, R7 with mem_rdata, on consecutive cycles.
   - mem_addr sequence is 0x2000, 0x2004, 0x2008.
   - ldm_done pulses once after the R7 write; ldm_busy drops the following cycle.
3. Wait states and PC load. ldm_list=0x8002, mem_rvalid delayed 3 cycles per request:
   - mem_addr is held stable while waiting.
   - Writes R1 then R15; pc_load=1 only on the R15 write.
4. Empty and overlapping requests:
   - ldm_list=0 -> ldm_done one cycle after start, no mem_req, no writes.
   - ldm_start together with wb_en in IDLE -> single write dropped.
5. Reset mid-sequence. ldm_list=0xFFFF, rst asserted after the 2nd write -> all outputs 0 next cycle, no ldm_done. A subsequent ldm_list=0x0001 runs cleanly.
6. Address wrap. ldm_base=0xFFFFFFFC, ldm_list=0x0003 -> addresses 0xFFFFFFFC then 0x00000000.

Source files
------------

// File: rtl/wb_ldm_sequencer.sv
// Register-file writeback unit: one-cycle single-write mux plus an LDM/POP
// sequencer that issues one read per set list bit and writes each returned word.
module wb_ldm_sequencer #(
  parameter int DW   = 32,
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      wb_src,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [DW-1:0]   alu_result,
  input  logic [DW-1:0]   r_mem_data_with_extend,
  input  logic [DW-1:0]   pc_real,
  input  logic            ldm_start,
  input  logic [NREG-1:0] ldm_list,
  input  logic [DW-1:0]   ldm_base,
  output logic            mem_req,
  output logic [DW-1:0]   mem_addr,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            w_reg_en,
  output logic [AW-1:0]   w_reg_addr,
  output logic [DW-1:0]   w_reg_data,
  output logic            ldm_busy,
  output logic            ldm_done,
  output logic            pc_load
);

  typedef enum logic [1:0] {IDLE, REQ, LAST} state_t;

  localparam logic [2:0] SRC_ALU = 3'd0;
  localparam logic [2:0] SRC_MEM = 3'd1;
  localparam logic [2:0] SRC_BLX = 3'd5;
  localparam logic [2:0] SRC_BL  = 3'd6;

  state_t          r_state;
  logic [NREG-1:0] r_list;
  logic [DW-1:0]   r_addr;
  logic            r_mem_req;
  logic            r_reg_en;
  logic [AW-1:0]   r_reg_addr;
  logic [DW-1:0]   r_reg_data;
  logic            r_busy;
  logic            r_done;
  logic            r_pc_load;

  logic [AW-1:0]   w_lowIdx;
  logic [NREG-1:0] w_listNext;
  logic [DW-1:0]   w_link;
  logic            w_wbValid;
  logic [DW-1:0]   w_wbData;

  // Lowest set bit of the remaining list, and the list with that bit removed
  always_comb begin
    w_lowIdx = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (r_list[i]) w_lowIdx = AW'(i);
    end
    w_listNext = r_list & (r_list - NREG'(1));
  end

  // Thumb link values keep bit 0 set; BL points back over the 2-byte suffix
  always_comb begin
    w_link    = {pc_real[DW-1:1], 1'b1};
    w_wbValid = 1'b1;
    w_wbData  = alu_result;
    case (wb_src)
      SRC_ALU: w_wbData = alu_result;
      SRC_MEM: w_wbData = r_mem_data_with_extend;
      SRC_BLX: w_wbData = w_link;
      SRC_BL:  w_wbData = w_link - DW'(2);
      default: w_wbValid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_list     <= '0;
      r_addr     <= '0;
      r_mem_req  <= 1'b0;
      r_reg_en   <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pc_load  <= 1'b0;
    end else begin
      r_reg_en  <= 1'b0;
      r_pc_load <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (ldm_start) begin
            r_busy <= 1'b1;
            if (ldm_list != '0) begin
              r_list    <= ldm_list;
              r_addr    <= ldm_base;
              r_mem_req <= 1'b1;
              r_state   <= REQ;
            end else begin
              r_done  <= 1'b1;
              r_state <= LAST;
            end
          end else if (wb_en && w_wbValid) begin
            r_reg_en   <= 1'b1;
            r_reg_addr <= wb_addr;
            r_reg_data <= w_wbData;
          end
        end
        REQ: begin
          if (mem_rvalid) begin
            r_reg_en   <= 1'b1;
            r_reg_addr <= w_lowIdx;
            r_reg_data <= mem_rdata;
            r_pc_load  <= (w_lowIdx == AW'(NREG - 1));
            r_list     <= w_listNext;
            r_addr     <= r_addr + DW'(DW / 8);
            if (w_listNext == '0) begin
              r_mem_req <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= LAST;
            end
          end
        end
        LAST: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_addr   = r_addr;
  assign w_reg_en   = r_reg_en;
  assign w_reg_addr = r_reg_addr;
  assign w_reg_data = r_reg_data;
  assign ldm_busy   = r_busy;
  assign ldm_done   = r_done;
  assign pc_load    = r_pc_load;

endmodule

// File: tb/tb_wb_ldm_sequencer.sv
// Directed bench for wb_ldm_sequencer: single writes, list sequencing,
// wait states, empty/overlapping starts, mid-sequence reset and address wrap.
module tb_wb_ldm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  wb_src;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] alu_result;
  logic [31:0] r_mem_data_with_extend;
  logic [31:0] pc_real;
  logic        ldm_start;
  logic [15:0] ldm_list;
  logic [31:0] ldm_base;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        w_reg_en;
  logic [3:0]  w_reg_addr;
  logic [31:0] w_reg_data;
  logic        ldm_busy;
  logic        ldm_done;
  logic        pc_load;

  int totalChecks = 0;
  int badChecks   = 0;

  wb_ldm_sequencer #(.DW(32), .NREG(16), .AW(4)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .wb_src                 (wb_src),
    .wb_en                  (wb_en),
    .wb_addr                (wb_addr),
    .alu_result             (alu_result),
    .r_mem_data_with_extend (r_mem_data_with_extend),
    .pc_real                (pc_real),
    .ldm_start              (ldm_start),
    .ldm_list               (ldm_list),
    .ldm_base               (ldm_base),
    .mem_req                (mem_req),
    .mem_addr               (mem_addr),
    .mem_rvalid             (mem_rvalid),
    .mem_rdata              (mem_rdata),
    .w_reg_en               (w_reg_en),
    .w_reg_addr             (w_reg_addr),
    .w_reg_data             (w_reg_data),
    .ldm_busy               (ldm_busy),
    .ldm_done               (ldm_done),
    .pc_load                (pc_load)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkWrite(input string tag, input logic en, input logic [3:0] addr,
                            input logic [31:0] data, input logic pcl);
    checkOutput({tag, ".en"}, {31'd0, w_reg_en}, {31'd0, en});
    if (en) begin
      checkOutput({tag, ".addr"}, {28'd0, w_reg_addr}, {28'd0, addr});
      checkOutput({tag, ".data"}, w_reg_data, data);
    end
    checkOutput({tag, ".pcload"}, {31'd0, pc_load}, {31'd0, pcl});
  endtask

  task automatic checkCtl(input string tag, input logic req, input logic busy,
                          input logic done);
    checkOutput({tag, ".req"},  {31'd0, mem_req},  {31'd0, req});
    checkOutput({tag, ".busy"}, {31'd0, ldm_busy}, {31'd0, busy});
    checkOutput({tag, ".done"}, {31'd0, ldm_done}, {31'd0, done});
  endtask

  task automatic checkAllZero(input string tag);
    checkCtl(tag, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, ".en"},   {31'd0, w_reg_en}, 32'd0);
    checkOutput({tag, ".addr"}, {28'd0, w_reg_addr}, 32'd0);
    checkOutput({tag, ".data"}, w_reg_data, 32'd0);
    checkOutput({tag, ".maddr"}, mem_addr, 32'd0);
    checkOutput({tag, ".pcload"}, {31'd0, pc_load}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; wb_src = 3'd0; wb_en = 1'b0; wb_addr = 4'd0;
    alu_result = 32'd0; r_mem_data_with_extend = 32'd0; pc_real = 32'd0;
    ldm_start = 1'b0; ldm_list = 16'd0; ldm_base = 32'd0;
    mem_rvalid = 1'b0; mem_rdata = 32'd0;
    applyStimulus();
    applyStimulus();
    checkAllZero("reset");
    rst = 1'b0;

    // Single writes
    wb_en = 1'b1; wb_addr = 4'd3; wb_src = 3'd0; alu_result = 32'h1234;
    r_mem_data_with_extend = 32'hDEAD_0001; pc_real = 32'h100;
    applyStimulus();
    checkWrite("sw_alu", 1'b1, 4'd3, 32'h1234, 1'b0);
    wb_src = 3'd1; wb_addr = 4'd9;
    applyStimulus();
    checkWrite("sw_mem", 1'b1, 4'd9, 32'hDEAD_0001, 1'b0);
    wb_src = 3'd6; wb_addr = 4'd14;
    applyStimulus();
    checkWrite("sw_bl", 1'b1, 4'd14, 32'h0000_00FF, 1'b0);
    wb_src = 3'd5;
    applyStimulus();
    checkWrite("sw_blx", 1'b1, 4'd14, 32'h0000_0101, 1'b0);
    wb_src = 3'd2;
    applyStimulus();
    checkWrite("sw_bad", 1'b0, 4'd0, 32'd0, 1'b0);
    checkOutput("sw_bad.hold", w_reg_data, 32'h0000_0101);
    wb_en = 1'b0; wb_src = 3'd0;
    applyStimulus();
    checkWrite("sw_off", 1'b0, 4'd0, 32'd0, 1'b0);

    // Basic multi-load, list 0x0091, zero wait states
    ldm_start = 1'b1; ldm_list = 16'h0091; ldm_base = 32'h2000; mem_rvalid = 1'b1;
    applyStimulus();
    ldm_start = 1'b0; ldm_list = 16'd0;
    checkCtl("b_req", 1'b1, 1'b1, 1'b0);
    checkOutput("b_addr0", mem_addr, 32'h2000);
    checkWrite("b_nowr", 1'b0, 4'd0, 32'd0, 1'b0);
    mem_rdata = 32'hA0;
    applyStimulus();
    checkWrite("b_r0", 1'b1, 4'd0, 32'hA0, 1'b0);
    checkOutput("b_addr1", mem_addr, 32'h2004);
    mem_rdata = 32'hA4;
    applyStimulus();
    checkWrite("b_r4", 1'b1, 4'd4, 32'hA4, 1'b0);
    checkOutput("b_addr2", mem_addr, 32'h2008);
    checkCtl("b_mid", 1'b1, 1'b1, 1'b0);
    mem_rdata = 32'hA8;
    applyStimulus();
    checkWrite("b_r7", 1'b1, 4'd7, 32'hA8, 1'b0);
    checkCtl("b_last", 1'b0, 1'b1, 1'b1);
    applyStimulus();
    checkCtl("b_idle", 1'b0, 1'b0, 1'b0);
    checkWrite("b_idlewr", 1'b0, 4'd0, 32'd0, 1'b0);
    mem_rvalid = 1'b0;

    // Wait states and PC load, list 0x8002
    ldm_start = 1'b1; ldm_list = 16'h8002; ldm_base = 32'h3000;
    applyStimulus();
    ldm_start = 1'b0;
    checkOutput("w_addr0a", mem_addr, 32'h3000);
    applyStimulus();
    checkOutput("w_addr0b", mem_addr, 32'h3000);
    checkWrite("w_wait0", 1'b0, 4'd0, 32'd0, 1'b0);
    applyStimulus();
    checkOutput("w_addr0c", mem_addr, 32'h3000);
    mem_rvalid = 1'b1; mem_rdata = 32'h11;
    applyStimulus();
    mem_rvalid = 1'b0;
    checkWrite("w_r1", 1'b1, 4'd1, 32'h11, 1'b0);
    checkOutput("w_addr1a", mem_addr, 32'h3004);
    applyStimulus();
    checkOutput("w_addr1b", mem_addr, 32'h3004);
    checkCtl("w_wait1", 1'b1, 1'b1, 1'b0);
    applyStimulus();
    mem_rvalid = 1'b1; mem_rdata = 32'h8000_0001;
    applyStimulus();
    mem_rvalid = 1'b0;
    checkWrite("w_r15", 1'b1, 4'd15, 32'h8000_0001, 1'b1);
    checkCtl("w_last", 1'b0, 1'b1, 1'b1);
    applyStimulus();
    checkCtl("w_idle", 1'b0, 1'b0, 1'b0);

    // Empty list
    ldm_start = 1'b1; ldm_list = 16'd0;
    applyStimulus();
    ldm_start = 1'b0;
    checkCtl("e_last", 1'b0, 1'b1, 1'b1);
    checkWrite("e_nowr", 1'b0, 4'd0, 32'd0, 1'b0);
    applyStimulus();
    checkCtl("e_idle", 1'b0, 1'b0, 1'b0);

    // ldm_start wins over a simultaneous single write
    wb_en = 1'b1; wb_src = 3'd0; wb_addr = 4'd5; alu_result = 32'h55;
    ldm_start = 1'b1; ldm_list = 16'h0001; ldm_base = 32'h4000;
    applyStimulus();
    wb_en = 1'b0; ldm_start = 1'b0;
    checkWrite("o_drop", 1'b0, 4'd0, 32'd0, 1'b0);
    checkCtl("o_req", 1'b1, 1'b1, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    applyStimulus();
    mem_rvalid = 1'b0;
    checkWrite("o_r0", 1'b1, 4'd0, 32'h77, 1'b0);
    checkCtl("o_last", 1'b0, 1'b1, 1'b1);
    applyStimulus();

    // Reset after the second write of a full list
    ldm_start = 1'b1; ldm_list = 16'hFFFF; ldm_base = 32'h5000; mem_rvalid = 1'b1;
    applyStimulus();
    ldm_start = 1'b0;
    mem_rdata = 32'hB0;
    applyStimulus();
    checkWrite("r_r0", 1'b1, 4'd0, 32'hB0, 1'b0);
    mem_rdata = 32'hB1;
    applyStimulus();
    checkWrite("r_r1", 1'b1, 4'd1, 32'hB1, 1'b0);
    rst = 1'b1;
    applyStimulus();
    checkAllZero("r_abort");
    rst = 1'b0; mem_rvalid = 1'b0;
    applyStimulus();
    checkCtl("r_after", 1'b0, 1'b0, 1'b0);
    checkWrite("r_afterwr", 1'b0, 4'd0, 32'd0, 1'b0);
    ldm_start = 1'b1; ldm_list = 16'h0001; ldm_base = 32'h6000;
    applyStimulus();
    ldm_start = 1'b0;
    checkOutput("r_addr", mem_addr, 32'h6000);
    mem_rvalid = 1'b1; mem_rdata = 32'h66;
    applyStimulus();
    mem_rvalid = 1'b0;
    checkWrite("r_rerun", 1'b1, 4'd0, 32'h66, 1'b0);
    checkCtl("r_done", 1'b0, 1'b1, 1'b1);
    applyStimulus();

    // Address wrap
    ldm_start = 1'b1; ldm_list = 16'h0003; ldm_base = 32'hFFFF_FFFC; mem_rvalid = 1'b1;
    applyStimulus();
    ldm_start = 1'b0;
    checkOutput("a_addr0", mem_addr, 32'hFFFF_FFFC);
    mem_rdata = 32'hC0;
    applyStimulus();
    checkWrite("a_r0", 1'b1, 4'd0, 32'hC0, 1'b0);
    checkOutput("a_addr1", mem_addr, 32'h0000_0000);
    mem_rdata = 32'hC1;
    applyStimulus();
    mem_rvalid = 1'b0;
    checkWrite("a_r1", 1'b1, 4'd1, 32'hC1, 1'b0);
    checkCtl("a_last", 1'b0, 1'b1, 1'b1);
    applyStimulus();
    checkCtl("a_idle", 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
